// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel deserialiser.
package s2p_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit-count register width, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/s2p_shift_reg.sv
// WIDTH-bit deserialising shift register; word_o is the value taken on the coming edge.
module s2p_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // LSB-first enters at the top and moves down, so bit 0 ends at position 0 after WIDTH bits.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = '0;
      if (MSB_FIRST) sr_d[0] = d_i;
      else           sr_d[WIDTH-1] = d_i;
    end else if (shift_i) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], d_i} : {d_i, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign word_o = sr_d;

endmodule

// File: rtl/serial2parallel_gen.sv
// Parametrised serial-to-parallel deserialiser with valid/ready output and overrun flag.
module serial2parallel_gen
  import s2p_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_start,
  input  logic             d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] a,
  output logic             a_valid,
  input  logic             a_ready,
  output logic             end_conversion,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic             a_valid_q, eoc_q, overrun_q;
  logic [WIDTH-1:0] word_d;
  logic             load, shift_en;

  assign load     = d_valid && serial_start;
  assign shift_en = d_valid && !serial_start && (state_q == SHIFT);

  s2p_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (load),
    .shift_i(shift_en),
    .d_i    (d),
    .word_o (word_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      eoc_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      eoc_q <= 1'b0;
      if (a_valid_q && a_ready) a_valid_q <= 1'b0;
      if (load) begin
        cnt_q   <= CW'(1);
        state_q <= SHIFT;
      end else if (shift_en) begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_q   <= '0;
          state_q <= IDLE;
          // A consumer taking the old word on this edge frees the slot for the new one.
          if (!a_valid_q || a_ready) begin
            a_q       <= word_d;
            a_valid_q <= 1'b1;
            eoc_q     <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign a              = a_q;
  assign a_valid        = a_valid_q;
  assign end_conversion = eoc_q;
  assign busy           = (state_q == SHIFT);
  assign overrun        = overrun_q;

endmodule
